// File: rtl/dmem_bus_ctrl.sv
// Load/store controller bridging the core's zero-wait data-memory port to a
// variable-latency valid/ready memory bus: posted stores, stalling loads.
module dmem_bus_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic [DATA_W-1:0] cpu_rd,
    output logic              stall,
    output logic              align_err,
    output logic              bus_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRAIN   = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RD_DONE = 3'd4;

    localparam int unsigned       CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF);

    logic [2:0]        state_q, state_d;
    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              misaligned;
    logic              wb_state;
    logic              wb_drive;
    logic              wb_hs;
    logic              timeout_hit;
    logic              stall_c;
    logic              align_c;
    logic [ADDR_W-1:0] word_addr;

    assign word_addr   = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign misaligned  = (cpu_re | cpu_we) & (cpu_addr[1:0] != 2'b00);
    assign wb_state    = (state_q == S_IDLE) | (state_q == S_DRAIN);
    assign wb_drive    = wb_valid_q & wb_state;
    assign wb_hs       = wb_drive & mem_req_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state, write-buffer and core-side handshake logic
    always_comb begin
        state_d    = state_q;
        wb_valid_d = wb_valid_q & ~wb_hs;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        stall_c    = 1'b0;
        align_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (misaligned) begin
                    align_c = 1'b1;
                end else if (cpu_we) begin
                    // A store may take the slot in the same cycle the old entry drains.
                    if (!wb_valid_q || wb_hs) begin
                        wb_valid_d = 1'b1;
                        wb_addr_d  = word_addr;
                        wb_data_d  = cpu_wd;
                    end else begin
                        stall_c = 1'b1;
                    end
                end else if (cpu_re) begin
                    stall_c = 1'b1;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (wb_valid_q && !wb_hs) ? S_DRAIN : S_RD_REQ;
                end
            end

            S_DRAIN: begin
                stall_c = 1'b1;
                if (wb_hs) begin
                    cnt_d   = '0;
                    state_d = S_RD_REQ;
                end
            end

            S_RD_REQ: begin
                stall_c = 1'b1;
                if (timeout_hit) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = S_RD_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (mem_req_ready) begin
                        state_d = S_RD_WAIT;
                    end
                end
            end

            S_RD_WAIT: begin
                stall_c = 1'b1;
                if (mem_rsp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_RD_DONE;
                end else if (timeout_hit) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = S_RD_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_RD_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus request mux: buffered write in IDLE/DRAIN, read address in RD_REQ
    always_comb begin
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (wb_drive) begin
            mem_req_valid = 1'b1;
            mem_we        = 1'b1;
            mem_addr      = wb_addr_q;
            mem_wdata     = wb_data_q;
        end else if (state_q == S_RD_REQ) begin
            mem_req_valid = 1'b1;
            mem_addr      = word_addr;
        end
    end

    // Combinational core-side flags are forced low while reset is held.
    assign stall     = stall_c & ~rst;
    assign align_err = align_c & ~rst;
    assign bus_err   = (state_q == S_RD_DONE) & err_q;
    assign cpu_rd    = rdata_q;

endmodule
